// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int unsigned WIDTH_DEF  = 14;
   localparam int unsigned DIGITS_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Largest value representable in the given number of decimal digits.
   function automatic longint unsigned max_dec(input int unsigned digits);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   // Bit counter width able to hold the value WIDTH.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Correct before the shift so the digit carries cleanly into the next one.
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = 4'(din + 4'd3);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to BCD converter, one bit per clock, MSB first.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int unsigned       CW      = cnt_width(WIDTH);
   localparam int unsigned       BW      = 4 * DIGITS;
   localparam longint unsigned   MAX_VAL = max_dec(DIGITS);
   localparam logic [BW-1:0]     NINES   = {DIGITS{4'h9}};

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  bin_sr;
   logic [BW-1:0]     scratch;
   logic [BW-1:0]     corr;
   logic [BW-1:0]     shifted;
   logic              ovf_pend;
   logic              last_shift;

   // One correction cell per scratch digit.
   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      add3 u_add3 (
         .din  (scratch[4*i +: 4]),
         .dout (corr[4*i +: 4])
      );
   end

   assign shifted    = {corr[BW-2:0], bin_sr[WIDTH-1]};
   assign last_shift = (cnt == CW'(1));
   assign busy       = (state == SHIFT);

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_shift) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath: capture on accept, shift while busy, publish result on the last shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         bin_sr   <= '0;
         scratch  <= '0;
         ovf_pend <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr   <= bin;
                  scratch  <= '0;
                  cnt      <= CW'(WIDTH);
                  ovf_pend <= (64'(bin) > MAX_VAL);
               end
            end
            SHIFT: begin
               scratch <= shifted;
               bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
               cnt     <= cnt - CW'(1);
               if (last_shift) begin
                  bcd      <= ovf_pend ? NINES : shifted;
                  overflow <= ovf_pend;
                  done     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq at default parameters.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin;
   logic        busy;
   logic        done;
   logic [15:0] bcd;
   logic        overflow;

   int total;
   int bad;
   bit chk_en;

   typedef struct {
      logic [13:0] bin;
      logic [15:0] exp_bcd;
      logic        exp_ovf;
   } vec_t;

   bin2bcd_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Decimal reference from plain arithmetic; saturates to all nines.
   function automatic logic [15:0] ref_bcd(input int unsigned v);
      logic [15:0]  r;
      int unsigned  p;
      r = '0;
      if (v > 9999) return 16'h9999;
      p = 1;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Every digit in range on every cycle once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 4; d++) begin
            total++;
            if (bcd[4*d +: 4] > 4'd9) begin
               bad++;
               $display("FAIL digit_range: digit %0d = %0h, required <= 9", d, bcd[4*d +: 4]);
            end
         end
      end
   end

   // Called at the first negedge after the accepting edge; waits for done.
   task automatic wait_done(output int lat, output bit busy_ok, output bit stable_ok,
                            input int inject_at);
      logic [15:0] prev;
      logic        prev_ovf;
      lat       = 0;
      busy_ok   = 1'b1;
      stable_ok = 1'b1;
      prev      = bcd;
      prev_ovf  = overflow;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (bcd !== prev || overflow !== prev_ovf) stable_ok = 1'b0;
         if (lat == inject_at) begin
            start = 1'b1;
            bin   = 14'd42;
         end else if (lat == inject_at + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                           input int inject_at);
      int lat;
      bit bok;
      bit sok;
      start = 1'b1;
      bin   = v;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bok, sok, inject_at);
      check($sformatf("latency bin=%0d", v), 32'(lat), 32'd14);
      check($sformatf("busy_during bin=%0d", v), 32'(bok), 32'd1);
      check($sformatf("hold_mid bin=%0d", v), 32'(sok), 32'd1);
      check($sformatf("bcd bin=%0d", v), 32'(bcd), 32'(eb));
      check($sformatf("ovf bin=%0d", v), 32'(overflow), 32'(eo));
      check($sformatf("busy_at_done bin=%0d", v), 32'(busy), 32'd0);
      @(negedge clk);
      check($sformatf("done_width bin=%0d", v), 32'(done), 32'd0);
      check($sformatf("idle_after bin=%0d", v), 32'(busy), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int          k;
      int          first;
      int          second;
      bit          saw_done;
      int unsigned r;

      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      rst    = 1'b1;
      start  = 1'b0;
      bin    = '0;

      vecs.push_back('{14'd1234,  16'h1234, 1'b0});
      vecs.push_back('{14'd0,     16'h0000, 1'b0});
      vecs.push_back('{14'd9999,  16'h9999, 1'b0});
      vecs.push_back('{14'd10000, 16'h9999, 1'b1});
      vecs.push_back('{14'd16383, 16'h9999, 1'b1});
      vecs.push_back('{14'd1,     16'h0001, 1'b0});
      vecs.push_back('{14'd9,     16'h0009, 1'b0});
      vecs.push_back('{14'd10,    16'h0010, 1'b0});
      vecs.push_back('{14'd99,    16'h0099, 1'b0});
      vecs.push_back('{14'd100,   16'h0100, 1'b0});
      vecs.push_back('{14'd8000,  16'h8000, 1'b0});
      vecs.push_back('{14'd5555,  16'h5555, 1'b0});

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset bcd", 32'(bcd), 32'd0);
      check("reset ovf", 32'(overflow), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset busy", 32'(busy), 32'd0);

      foreach (vecs[i]) begin
         run_conv(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf, -1);
      end

      // Start pulse while busy must be ignored.
      run_conv(14'd5678, 16'h5678, 1'b0, 4);

      // Reset mid-conversion aborts without a done pulse.
      start = 1'b1;
      bin   = 14'd8765;
      @(negedge clk);
      start    = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c < 7; c++) begin
         if (done) saw_done = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort no_done", 32'(saw_done | done), 32'd0);
      check("abort bcd", 32'(bcd), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort ovf", 32'(overflow), 32'd0);
      run_conv(14'd31, 16'h0031, 1'b0, -1);

      // Start held high: back-to-back conversions.
      start  = 1'b1;
      bin    = 14'd100;
      k      = 0;
      first  = -1;
      second = -1;
      while (second < 0 && k < 60) begin
         @(negedge clk);
         k++;
         if (k == 1) bin = 14'd2500;
         if (done) begin
            if (first < 0) begin
               first = k;
               check("b2b first bcd", 32'(bcd), 32'h0100);
            end else begin
               second = k;
               start  = 1'b0;
               check("b2b second bcd", 32'(bcd), 32'h2500);
            end
         end
      end
      check("b2b both_seen", 32'(first > 0 && second > 0), 32'd1);
      check("b2b spacing", 32'(second - first), 32'd15);
      @(negedge clk);
      @(negedge clk);
      check("b2b idle", 32'(busy), 32'd0);

      // Random values against the decimal reference.
      for (int n = 0; n < 1000; n++) begin
         r = $urandom_range(0, 16383);
         run_conv(14'(r), ref_bcd(r), (r > 9999), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 14, binary input width in bits (WIDTH >= 4).
REQ-002 Parameter DIGITS, default 4, number of BCD output digits.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high, sampled on clk rising edge.
REQ-005 Port start  input  1  conversion request; single-cycle pulse or level.
REQ-006 Port bin  input  WIDTH  unsigned binary value; sampled only when start is accepted.
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port done  output  1  one-cycle pulse marking the cycle in which bcd and overflow become valid.
REQ-009 Port bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]; held between conversions.
REQ-010 Port overflow  output  1  high when the last accepted bin exceeded 10^DIGITS-1; held with bcd.

Function
REQ-011 Algorithm SHALL be iterative shift-and-add-3 (double dabble), one bin bit consumed per clock, MSB first.
REQ-012 States SHALL be IDLE and SHIFT only; busy = (state == SHIFT), decoded combinationally from the state register.
REQ-013 In IDLE with start=1, the block SHALL capture bin, clear the BCD scratch register, load bit counter with WIDTH, and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL apply add-3 correction to every scratch digit >= 5, then shift {scratch, binary} left by one, decrementing the counter.
REQ-015 On the edge performing the final shift, the block SHALL write the result to bcd, set done=1 for exactly one cycle, and return to IDLE.
REQ-016 Latency SHALL be WIDTH clock edges from the start-accepting edge to done rising (14 at default); throughput one conversion per WIDTH+1 cycles.
REQ-017 start while busy=1 SHALL be ignored, with no queuing and no effect on the running conversion.
REQ-018 start during the done cycle SHALL be accepted, because state is IDLE in that cycle.
REQ-019 If captured bin > 10^DIGITS-1, the block SHALL drive overflow=1 and bcd to all-nines at done; otherwise overflow=0 and bcd holds the exact value.
REQ-020 bcd and overflow SHALL change only on the done edge or on reset, never mid-conversion.
REQ-021 Every bcd digit SHALL be in the range 0..9 at all times.

Reset
REQ-022 rst=1 SHALL force state=IDLE, bcd=0, overflow=0, done=0 and counter=0 at the next edge, and busy SHALL then read 0.
REQ-023 rst has priority over start; rst asserted mid-conversion SHALL abort the conversion with no done pulse, and bcd SHALL read 0.

Structure
REQ-024 Shared package bcd_pkg SHALL hold the state enum, the WIDTH/DIGITS defaults, and the function computing 10^DIGITS-1 and the counter width clog2(WIDTH+1).
REQ-025 The existing add3 digit-correction cell SHALL be instantiated DIGITS times, once per scratch digit, as the only sub-module.
REQ-026 All outputs except busy SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-027 Reset, then start with bin=1234 -> done exactly 14 cycles later; bcd=16'h1234, overflow=0; busy high for 14 cycles.
REQ-028 Boundaries: bin=0 -> bcd=16'h0000; bin=9999 -> bcd=16'h9999, overflow=0; bin=10000 -> bcd=16'h9999, overflow=1.
REQ-029 Start bin=5678, then pulse start with bin=42 on cycle 5 -> bin=42 ignored; done yields bcd=16'h5678.
REQ-030 Start bin=8765, then assert rst at cycle 7 -> no done pulse; bcd=0, busy=0 the cycle after; a new start with bin=31 -> bcd=16'h0031.
REQ-031 Back-to-back conversions with start held high continuously, bin=100 then 2500 -> consecutive done pulses 15 cycles apart; bcd=16'h0100 then 16'h2500.
REQ-032 Random bin over 0..16383, 1000 runs, checked against a reference model -> all results match; every digit <= 9 on every cycle.
